// File: rtl/led_pkg.sv
// Shared mode encodings and bounce direction type for the LED bank driver.
package led_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] LED_OFF    = 3'd0;
    localparam logic [MODE_W-1:0] LED_ON     = 3'd1;
    localparam logic [MODE_W-1:0] LED_CHASE  = 3'd2;
    localparam logic [MODE_W-1:0] LED_BOUNCE = 3'd3;
    localparam logic [MODE_W-1:0] LED_COUNT  = 3'd4;
    localparam logic [MODE_W-1:0] LED_DIM    = 3'd5;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/led_prescaler.sv
// Pattern step prescaler: counts 0..STEP_DIV-1 and pulses step_tick on the last count.
// Latency: first tick STEP_DIV cycles after reset release; no backpressure.
module led_prescaler #(
    parameter int STEP_DIV = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    output logic step_tick
);

    localparam int CW = $clog2(STEP_DIV);
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign step_tick = (cnt == LAST);

endmodule

// File: rtl/led_bank_driver.sv
// LED bank pattern driver with valid/ready config applied only on step boundaries.
// Latency: config visible on led the cycle after the next step tick; one config may be pending.
module led_bank_driver
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 16,
    parameter int STEP_DIV = 1000000,
    parameter int PWM_W    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [MODE_W-1:0]   cfg_mode,
    input  logic [PWM_W-1:0]    cfg_duty,
    output logic                step_tick,
    output logic [NUM_LEDS-1:0] led
);

    localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_LEDS - 1);

    logic                pend;
    logic [MODE_W-1:0]   pend_mode;
    logic [PWM_W-1:0]    pend_duty;
    logic [MODE_W-1:0]   mode,     nxt_mode;
    logic [PWM_W-1:0]    duty,     nxt_duty;
    logic [POS_W-1:0]    pos,      nxt_pos;
    dir_t                dir,      nxt_dir;
    logic [NUM_LEDS-1:0] cnt,      nxt_cnt;
    logic [PWM_W-1:0]    pwm_cnt;
    logic [NUM_LEDS-1:0] led_nxt;
    logic [NUM_LEDS-1:0] onehot;
    logic                apply;
    logic                advance;

    led_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_prescaler (
        .clk       (clk),
        .reset_n   (reset_n),
        .step_tick (step_tick)
    );

    assign cfg_ready = ~pend;
    assign apply     = step_tick & pend;
    assign advance   = step_tick & ~pend;

    always_comb begin
        nxt_mode = mode;
        nxt_duty = duty;
        nxt_pos  = pos;
        nxt_dir  = dir;
        nxt_cnt  = cnt;
        if (apply) begin
            nxt_mode = pend_mode;
            nxt_duty = pend_duty;
            nxt_pos  = '0;
            nxt_dir  = DIR_UP;
            nxt_cnt  = '0;
        end else if (advance) begin
            nxt_cnt = cnt + 1'b1;
            case (mode)
                LED_CHASE: nxt_pos = (pos == LAST_POS) ? '0 : pos + 1'b1;
                LED_BOUNCE: begin
                    // A single LED has nowhere to bounce to, so position stays 0.
                    if (NUM_LEDS > 1) begin
                        if (dir == DIR_UP) begin
                            if (pos == LAST_POS) begin
                                nxt_dir = DIR_DOWN;
                                nxt_pos = pos - 1'b1;
                            end else begin
                                nxt_pos = pos + 1'b1;
                            end
                        end else begin
                            if (pos == '0) begin
                                nxt_dir = DIR_UP;
                                nxt_pos = POS_W'(1);
                            end else begin
                                nxt_pos = pos - 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output is built from next state so a new step shows on led one cycle after its tick.
    always_comb begin
        onehot          = '0;
        onehot[nxt_pos] = 1'b1;
        case (nxt_mode)
            LED_ON:     led_nxt = {NUM_LEDS{1'b1}};
            LED_CHASE:  led_nxt = onehot;
            LED_BOUNCE: led_nxt = onehot;
            LED_COUNT:  led_nxt = nxt_cnt;
            LED_DIM:    led_nxt = {NUM_LEDS{pwm_cnt < nxt_duty}};
            default:    led_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend      <= 1'b0;
            pend_mode <= LED_OFF;
            pend_duty <= '0;
            mode      <= LED_OFF;
            duty      <= '0;
            pos       <= '0;
            dir       <= DIR_UP;
            cnt       <= '0;
            pwm_cnt   <= '0;
            led       <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            mode    <= nxt_mode;
            duty    <= nxt_duty;
            pos     <= nxt_pos;
            dir     <= nxt_dir;
            cnt     <= nxt_cnt;
            led     <= led_nxt;
            if (apply) begin
                pend <= 1'b0;
            end else if (cfg_valid && !pend) begin
                pend      <= 1'b1;
                pend_mode <= cfg_mode;
                pend_duty <= cfg_duty;
            end
        end
    end

endmodule

// File: tb/tb_led_bank_driver.sv
// Bench for led_bank_driver: directed table, corner sequences and a random run against a step-index model.
module tb_led_bank_driver;

    localparam int NL = 4;
    localparam int SD = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [2:0]    cfg_mode = 3'd0;
    logic [PW-1:0] cfg_duty = '0;
    logic          step_tick;
    logic [NL-1:0] led;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Model state: active mode/duty, steps taken since the last apply, pending request, cycle index.
    int m_mode, m_duty, m_k, m_pmode, m_pduty, mc;
    bit m_pend;
    logic [NL-1:0] m_led;

    led_bank_driver #(
        .NUM_LEDS (NL),
        .STEP_DIV (SD),
        .PWM_W    (PW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mode  (cfg_mode),
        .cfg_duty  (cfg_duty),
        .step_tick (step_tick),
        .led       (led)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [NL-1:0] pat(input int mode, input int k, input int duty, input int pwm);
        int p;
        case (mode)
            1: return {NL{1'b1}};
            2: return NL'(1 << (k % NL));
            3: begin
                p = k % (2 * NL - 2);
                if (p >= NL) p = 2 * NL - 2 - p;
                return NL'(1 << p);
            end
            4: return NL'(k % (1 << NL));
            5: return (pwm < duty) ? {NL{1'b1}} : {NL{1'b0}};
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit was, tick;
        if (!reset_n) begin
            m_mode = 0; m_duty = 0; m_k = 0; m_pend = 0;
            m_pmode = 0; m_pduty = 0; mc = 0; m_led = '0;
        end else begin
            tick = (mc % SD == SD - 1);
            was  = m_pend;
            if (tick && was) begin
                m_mode = m_pmode; m_duty = m_pduty; m_k = 0; m_pend = 0;
            end else if (tick) begin
                m_k++;
            end
            if (!was && cfg_valid) begin
                m_pend = 1; m_pmode = int'(cfg_mode); m_pduty = int'(cfg_duty);
            end
            m_led = pat(m_mode, m_k, m_duty, mc % (1 << PW));
            mc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_led", int'(led), int'(m_led));
            chk("model_ready", int'(cfg_ready), int'(!m_pend));
            chk("model_tick", int'(step_tick), int'(reset_n && (mc % SD == SD - 1)));
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send_cfg(input logic [2:0] mode, input logic [PW-1:0] duty);
        int n = 0;
        while (!cfg_ready && n < 3 * SD) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", int'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_mode  = mode;
        cfg_duty  = duty;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("ready_drop", int'(cfg_ready), 0);
    endtask

    task automatic wait_ready(input int lim);
        int n = 0;
        while (!cfg_ready && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("ready_back", int'(cfg_ready), 1);
    endtask

    typedef struct {
        string      name;
        logic [2:0] mode;
        logic [31:0] seq;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int ticks, hi, zeros;
        vecs[0] = '{"chase",  3'd2, 32'h8421_8421};
        vecs[1] = '{"bounce", 3'd3, 32'h2124_8421};
        vecs[2] = '{"count",  3'd4, 32'h7654_3210};
        vecs[3] = '{"on",     3'd1, 32'hFFFF_FFFF};
        vecs[4] = '{"off",    3'd0, 32'h0000_0000};
        vecs[5] = '{"rsv6",   3'd6, 32'h0000_0000};
        vecs[6] = '{"rsv7",   3'd7, 32'h0000_0000};

        repeat (3) @(negedge clk);
        chk("reset_led", int'(led), 0);
        chk("reset_ready", int'(cfg_ready), 1);
        chk("reset_tick", int'(step_tick), 0);
        chk_en = 1'b1;
        reset_n = 1'b1;

        ticks = 0;
        repeat (20) begin
            @(negedge clk);
            ticks += int'(step_tick);
        end
        chk("ticks_in_20", ticks, 5);
        chk("idle_led", int'(led), 0);

        foreach (vecs[v]) begin
            logic [31:0] s;
            s = vecs[v].seq;
            send_cfg(vecs[v].mode, '0);
            wait_ready(2 * SD + 2);
            chk({vecs[v].name, "_step0"}, int'(led), int'(s[3:0]));
            for (int i = 1; i < 8; i++) begin
                repeat (SD) @(negedge clk);
                chk({vecs[v].name, "_step"}, int'(led), int'(s[i*4 +: 4]));
            end
        end

        // Accept on the same edge as a tick: apply waits for the following tick.
        zeros = 0;
        while (!step_tick && zeros < 2 * SD) begin
            @(negedge clk);
            zeros++;
        end
        chk("found_tick", int'(step_tick), 1);
        cfg_valid = 1'b1; cfg_mode = 3'd2; cfg_duty = '0;
        @(negedge clk);
        cfg_valid = 1'b0;
        zeros = 0;
        while (!cfg_ready && zeros < 3 * SD) begin
            zeros++;
            @(negedge clk);
        end
        chk("same_edge_latency", zeros, SD);
        chk("same_edge_led", int'(led), 1);

        // Second request while pending is dropped.
        send_cfg(3'd4, '0);
        cfg_valid = 1'b1; cfg_mode = 3'd1;
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_ready(2 * SD + 2);
        chk("second_cfg_ignored", int'(led), 0);
        repeat (SD) @(negedge clk);
        chk("second_cfg_count1", int'(led), 1);

        // COUNT over 17 steps wraps back to zero.
        send_cfg(3'd4, '0);
        wait_ready(2 * SD + 2);
        for (int i = 0; i < 17; i++) begin
            chk("count17", int'(led), i % 16);
            repeat (SD) @(negedge clk);
        end

        // DIM duty cycles over one full PWM period.
        begin
            int duties[3] = '{64, 0, 255};
            foreach (duties[d]) begin
                send_cfg(3'd5, PW'(duties[d]));
                wait_ready(2 * SD + 2);
                hi = 0;
                repeat (1 << PW) begin
                    @(negedge clk);
                    if (led == {NL{1'b1}}) hi++;
                end
                chk("dim_high_cycles", hi, duties[d]);
            end
        end

        // Reset with a configuration pending.
        send_cfg(3'd1, '0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_led", int'(led), 0);
        chk("async_reset_ready", int'(cfg_ready), 1);
        chk("async_reset_tick", int'(step_tick), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_off", int'(led), 0);
        chk("post_reset_ready", int'(cfg_ready), 1);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_mode  = 3'($urandom_range(0, 7));
            cfg_duty  = PW'($urandom_range(0, 255));
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_bank_driver.md
# led_bank_driver

Parametrised driver for a bank of board LEDs. It extends the fixed all-off LED tie-off with runtime-selectable patterns: off, on, chase, bounce, binary count and PWM dim. The block sits between the host or control logic and the FPGA LED pins. A small valid/ready configuration port selects the pattern, and a new configuration is applied only on a pattern step boundary, so the LEDs never glitch mid-step.

## Interface
Parameters:
- NUM_LEDS, 16, number of LED outputs; minimum 1.
- STEP_DIV, 1000000, clock cycles per pattern step; minimum 2.
- PWM_W, 8, PWM counter and duty width.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  block can accept a configuration.
- cfg_mode  in  3  pattern select (see Operation).
- cfg_duty  in  PWM_W  PWM duty for mode DIM.
- step_tick  out  1  one-cycle pulse at each pattern step.
- led  out  NUM_LEDS  LED drive, active-high, registered.

## Operation
- Mode encoding:
  - 0 OFF: all LEDs 0.
  - 1 ON: all LEDs 1.
  - 2 CHASE: a single 1 walks from led[0] up to led[NUM_LEDS-1], then wraps to led[0].
  - 3 BOUNCE: a single 1 walks up to the top LED, reverses, walks down to led[0], reverses again.
  - 4 COUNT: led shows a binary counter that increments per step, modulo 2^NUM_LEDS.
  - 5 DIM: every LED = (pwm_cnt < duty).
  - 6 and 7 are reserved and behave as OFF.
- Prescaler:
  - Counts 0..STEP_DIV-1, then wraps.
  - step_tick=1 in the cycle the count equals STEP_DIV-1.
- PWM counter: free-running PWM_W-bit counter; wraps at 2^PWM_W.
- Config handshake:
  - cfg_ready=1 when no configuration is pending.
  - A transfer occurs when cfg_valid && cfg_ready. mode and duty are captured into pending registers and cfg_ready drops to 0.
  - cfg_valid while cfg_ready=0 is ignored (no transfer, no effect).
- Apply:
  - On the clock edge where step_tick=1 and a configuration is pending, active mode/duty take the pending values, the pattern state is initialised, and cfg_ready returns to 1 in the next cycle.
  - Initial pattern state: position 0, direction up, count 0.
  - No step advance happens on an apply edge.
- Step: on a step_tick edge with nothing pending, pattern state advances by one.
- BOUNCE state machine:
  - States UP and DOWN.
  - UP at position NUM_LEDS-1 goes to DOWN with position NUM_LEDS-2.
  - DOWN at position 0 goes to UP with position 1.
  - With NUM_LEDS=1, position stays 0 and led[0]=1 constantly.
- DIM: duty=0 gives LEDs always 0; duty=2^PWM_W-1 gives LEDs on for 255 of every 256 cycles (PWM_W=8).
- Reset: active mode OFF, duty 0, nothing pending, all counters 0.

## Timing
- Reset values: led=0, cfg_ready=1, step_tick=0.
- led is registered from the current pattern state.
  - New pattern state is visible on led one cycle after the tick edge.
  - DIM output lags pwm_cnt by one cycle.
- Config accepted at cycle t with the next tick at cycle T (T>t):
  - New mode is visible on led at T+1.
  - cfg_ready is 1 again at T+1.
  - If the accept and the tick fall in the same cycle, the apply happens at the next tick, not this one.
- Worst-case config latency: STEP_DIV+1 cycles.
- reset_n asserted mid-pattern or with a configuration pending: all state clears asynchronously and the pending configuration is discarded. After release, the first tick occurs STEP_DIV cycles later.

## Structure
- Shared package led_pkg holds:
  - the mode encodings (LED_OFF..LED_DIM) as named constants;
  - the mode width constant (3).
- Sub-module led_prescaler:
  - parameter STEP_DIV; ports clk, reset_n, step_tick;
  - counter and terminal-count pulse only.
- The top holds the config handshake, the pattern state and FSM, the PWM counter and the output register.

## Test plan
- Reset with STEP_DIV=4, NUM_LEDS=4, and hold for 20 cycles after release -> led=0000, cfg_ready=1, step_tick pulses every 4 cycles.
- Configure CHASE -> cfg_ready low until the next tick. led then steps 0001, 0010, 0100, 1000, 0001 with 4 cycles per step.
- Configure BOUNCE -> led sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- Configure COUNT with NUM_LEDS=4 and run 17 steps -> led 0000 through 1111, then wraps to 0000.
- Configure DIM with duty=64, PWM_W=8 -> exactly 64 high cycles per 256. duty=0 -> always 0.
- Issue a second cfg_valid while pending, then assert reset_n=0 with a configuration pending -> the second request is ignored, and reset gives led=0 and cfg_ready=1 immediately, with mode OFF after release.
